// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter: the CPU MEM stage competes with fixed-length VGA read bursts.
// A starvation counter caps how many contested cycles the CPU may win before a VGA beat is forced.
module dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int BURST_LEN  = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // VGA burst port
  input  logic              vga_enable,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_base,
  output logic              vga_ack,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_done,
  // RAM port
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // FSM state (0 = IDLE, 1 = BURST)
  output logic              o_dbg_state
);

  localparam int CNT_W    = $clog2(BURST_LEN + 1);
  localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_beat_addr;
  logic [ADDR_W-1:0]   w_beat_addr_nxt;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic [CNT_W-1:0]    w_beat_cnt_nxt;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic [STARVE_W-1:0] w_starve_nxt;

  // Owner tag for the read data returning from the RAM one cycle later.
  logic r_tag_cpu;
  logic r_tag_vga;
  logic r_tag_last;

  logic w_beat_live;
  logic w_cpu_grant;
  logic w_beat_issue;
  logic w_last_beat;
  logic w_ack;

  // Grant decision; a beat can only issue while the burst is live and reset is low.
  always_comb begin
    w_beat_live  = (r_state == ST_BURST) & vga_enable & ~reset;
    w_cpu_grant  = cpu_req;
    w_beat_issue = 1'b0;
    if (w_beat_live) begin
      if (!cpu_req) begin
        w_beat_issue = 1'b1;
      end else if (r_starve_cnt == STARVE_W'(STARVE_MAX)) begin
        w_beat_issue = 1'b1;
        w_cpu_grant  = 1'b0;
      end
    end
    w_last_beat = w_beat_issue & (r_beat_cnt == CNT_W'(1));
    w_ack       = (r_state == ST_IDLE) & vga_req & vga_enable & ~reset;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_addr_nxt = r_beat_addr;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_starve_nxt    = r_starve_cnt;
    case (r_state)
      ST_IDLE: begin
        w_starve_nxt = '0;
        if (w_ack) begin
          w_state_nxt     = ST_BURST;
          w_beat_addr_nxt = vga_base;
          w_beat_cnt_nxt  = CNT_W'(BURST_LEN);
        end
      end
      ST_BURST: begin
        if (!vga_enable) begin
          w_state_nxt  = ST_IDLE;
          w_starve_nxt = '0;
        end else if (w_beat_issue) begin
          w_beat_addr_nxt = r_beat_addr + ADDR_W'(1);
          w_beat_cnt_nxt  = r_beat_cnt - CNT_W'(1);
          w_starve_nxt    = '0;
          if (w_last_beat) begin
            w_state_nxt = ST_IDLE;
          end
        end else if (cpu_req) begin
          // Contested cycle won by the CPU.
          w_starve_nxt = r_starve_cnt + STARVE_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_beat_addr  <= '0;
      r_beat_cnt   <= '0;
      r_starve_cnt <= '0;
      r_tag_cpu    <= 1'b0;
      r_tag_vga    <= 1'b0;
      r_tag_last   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_beat_addr  <= w_beat_addr_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_tag_cpu    <= w_cpu_grant & ~cpu_we;
      r_tag_vga    <= w_beat_issue;
      r_tag_last   <= w_last_beat;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (w_cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end else if (w_beat_issue) begin
      mem_addr = r_beat_addr;
    end
  end

  assign cpu_stall   = cpu_req & ~w_cpu_grant;
  assign cpu_rvalid  = r_tag_cpu;
  assign cpu_rdata   = r_tag_cpu ? mem_rdata : '0;
  assign vga_ack     = w_ack;
  assign vga_rvalid  = r_tag_vga;
  assign vga_rdata   = r_tag_vga ? mem_rdata : '0;
  assign vga_done    = r_tag_vga & r_tag_last;
  assign o_dbg_state = r_state;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter that shares the Tessia data RAM between the pipeline's MEM stage and the VGA line fetcher. CPU accesses are single-beat, with stall feedback to the pipeline. VGA requests are fixed-length read bursts that the arbiter sequences internally. A starvation counter bounds how long CPU traffic can delay a pending VGA beat, so scan-out never underruns.

## Interface
Parameters:
- ADDR_W, 16, word-address width
- DATA_W, 32, data width
- BURST_LEN, 8, beats per VGA burst (≥1)
- STARVE_MAX, 4, contested cycles the CPU may win in a row during a burst before VGA is forced

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request (level, held while stalled)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_stall  out  1  request not granted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- vga_enable  in  1  VGA fetch enable (enableVGAX)
- vga_req  in  1  burst request (level)
- vga_base  in  ADDR_W  burst start address
- vga_ack  out  1  burst accepted (1-cycle pulse)
- vga_rvalid  out  1  burst beat data valid
- vga_rdata  out  DATA_W  burst beat data
- vga_done  out  1  marks the final beat (coincident with its vga_rvalid)
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after address

## Operation
- FSM states:
  - IDLE: no burst. vga_req & vga_enable → vga_ack=1 that cycle; latch base into beat address; beat count ← BURST_LEN; go to BURST.
  - BURST: one beat pending each cycle. A beat issued with count=1 → IDLE. vga_enable=0 → IDLE next cycle, with no further beats and no vga_done.
- No memory access occurs in the accept cycle. A new request is accepted only in IDLE.
- Grant, evaluated combinationally each cycle:
  - IDLE: CPU granted iff cpu_req.
  - BURST, no cpu_req: beat issued.
  - BURST with cpu_req: the beat is issued iff starve_cnt == STARVE_MAX; otherwise the CPU is granted.
- starve_cnt: increments when the CPU wins a contested BURST cycle, clears on beat issue, clears in IDLE. It never exceeds STARVE_MAX.
- cpu_stall = cpu_req & ~cpu_grant.
- Memory port:
  - CPU grant: mem_* driven from cpu_addr/cpu_we/cpu_wdata.
  - Beat issue: mem_addr = beat address, mem_we=0.
  - Neither: mem_we=0, mem_addr=0.
- Beat address increments by 1 per issued beat, modulo 2^ADDR_W (wrap from max to 0).
- Read return: a registered owner tag (CPU-read / VGA / none / last-flag) steers mem_rdata one cycle later.
  - cpu_rvalid follows CPU reads only; writes never produce rvalid.
  - vga_done asserts with the rvalid of beat BURST_LEN.
- cpu_rdata and vga_rdata mirror mem_rdata whenever their rvalid is high, and are 0 otherwise.

## Timing
- Reset values: FSM=IDLE, starve_cnt=0, owner tag=none. With cpu_req=0 and vga_req=0, every output is 0.
- Reset mid-burst: on the next edge the burst is dropped and pending rvalid/done are cancelled. No beat issues in the reset cycle.
- CPU read latency: 1 cycle from grant to cpu_rvalid. The stall is resolved combinationally in the same cycle.
- VGA: ack cycle T; beat 0 issued at T+1 at earliest; first vga_rvalid at T+2 at earliest.
- An uncontested burst finishes with vga_done at T+1+BURST_LEN.
- Worst-case beat delay under continuous CPU traffic: STARVE_MAX cycles. The effective beat period is STARVE_MAX+1.
- A beat already issued still returns its rvalid if vga_enable drops in the following cycle.
- Back-to-back bursts: new ack at the earliest the cycle after the last beat is issued. The in-flight rvalid/done for the previous burst is unaffected.
- CPU write followed by a CPU read of the same address on the next cycle returns the new data (RAM write-first, single port).

## Test plan
- Reset with BURST_LEN=4 → after reset all outputs 0, and vga_ack=0 even with vga_req=1 during reset.
- CPU write of 0xDEADBEEF to 0x0010, then read 0x0010 → cpu_stall=0 both cycles; cpu_rvalid the cycle after the read with cpu_rdata=0xDEADBEEF; no rvalid after the write.
- vga_req with base 0x0100, no CPU traffic, BURST_LEN=4 → ack at T; mem_addr 0x0100..0x0103 at T+1..T+4; vga_rvalid at T+2..T+5; vga_done only at T+5.
- Continuous cpu_req during the burst, STARVE_MAX=4 → pattern of 4 CPU grants then 1 beat (cpu_stall high that cycle), repeating; burst completes in 20 cycles.
- Base 0xFFFE, BURST_LEN=4 → beat addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Mid-burst abort:
  - vga_enable dropped after beat 2 issues → beat 2 rvalid still seen, no beat 3, no vga_done, FSM returns to IDLE.
  - Reset asserted after beat 1 → no further vga_rvalid.
